// File: rtl/wordle_guess_scorer.sv
// Wordle guess scorer: buffers keyboard letters, then scores a full guess against the answer.
// Scoring runs in two passes: greens in parallel, then one yellow position per cycle, left to right.
module wordle_guess_scorer #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
) (
  input  logic                         board_clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic [WORD_LEN*LETTER_W-1:0] answer,
  input  logic [LETTER_W-1:0]          letter_in,
  input  logic                         letter_push,
  input  logic                         letter_pop,
  input  logic                         submit,
  output logic [2:0]                   letter_count,
  output logic                         busy,
  output logic                         rejected,
  output logic [2*WORD_LEN-1:0]        result,
  output logic                         result_valid,
  output logic                         win
);

  localparam logic [2:0]          FULL       = 3'(WORD_LEN);
  localparam logic [2:0]          LAST_IDX   = 3'(WORD_LEN - 1);
  localparam logic [LETTER_W-1:0] MAX_LETTER = LETTER_W'(25);

  typedef enum logic [1:0] {COLLECT, GREEN, YELLOW, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            count_q, count_d;
  logic [LETTER_W-1:0]   guess_q [WORD_LEN];
  logic [LETTER_W-1:0]   guess_d [WORD_LEN];
  logic [LETTER_W-1:0]   answer_q [WORD_LEN];
  logic [LETTER_W-1:0]   answer_d [WORD_LEN];
  logic [WORD_LEN-1:0]   green_q, green_d;
  logic [WORD_LEN-1:0]   consumed_q, consumed_d;
  logic [WORD_LEN-1:0]   yellow_q, yellow_d;
  logic [2:0]            idx_q, idx_d;
  logic [2*WORD_LEN-1:0] result_q, result_d;
  logic                  win_q, win_d;
  logic                  busy_q, busy_d;
  logic                  rejected_q, rejected_d;
  logic                  result_valid_q, result_valid_d;
  logic                  match_found;
  logic [2:0]            match_k;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    guess_d        = guess_q;
    answer_d       = answer_q;
    green_d        = green_q;
    consumed_d     = consumed_q;
    yellow_d       = yellow_q;
    idx_d          = idx_q;
    result_d       = result_q;
    win_d          = win_q;
    rejected_d     = 1'b0;
    result_valid_d = 1'b0;
    match_found    = 1'b0;
    match_k        = 3'd0;

    case (state_q)
      COLLECT: begin
        if (submit) begin
          if (count_q == FULL) begin
            for (int i = 0; i < WORD_LEN; i++)
              answer_d[i] = answer[i*LETTER_W +: LETTER_W];
            state_d = GREEN;
          end else begin
            rejected_d = 1'b1;
          end
        end else if (letter_push && !letter_pop) begin
          if (count_q < FULL && letter_in <= MAX_LETTER) begin
            guess_d[count_q] = letter_in;
            count_d          = count_q + 3'd1;
          end
        end else if (letter_pop && !letter_push) begin
          if (count_q != 3'd0)
            count_d = count_q - 3'd1;
        end
      end

      GREEN: begin
        for (int i = 0; i < WORD_LEN; i++)
          green_d[i] = (guess_q[i] == answer_q[i]);
        consumed_d = green_d;
        yellow_d   = '0;
        idx_d      = 3'd0;
        state_d    = YELLOW;
      end

      YELLOW: begin
        // Descending scan so the lowest unclaimed matching answer slot wins.
        if (!green_q[idx_q]) begin
          for (int k = WORD_LEN - 1; k >= 0; k--) begin
            if (!consumed_q[k] && answer_q[k] == guess_q[idx_q]) begin
              match_found = 1'b1;
              match_k     = 3'(k);
            end
          end
          if (match_found) begin
            yellow_d[idx_q]     = 1'b1;
            consumed_d[match_k] = 1'b1;
          end
        end
        if (idx_q == LAST_IDX)
          state_d = DONE;
        else
          idx_d = idx_q + 3'd1;
      end

      DONE: begin
        for (int i = 0; i < WORD_LEN; i++)
          result_d[2*i +: 2] = green_q[i] ? 2'b10 : (yellow_q[i] ? 2'b01 : 2'b00);
        win_d          = &green_q;
        result_valid_d = 1'b1;
        count_d        = 3'd0;
        state_d        = COLLECT;
      end

      default: state_d = COLLECT;
    endcase

    if (clr) begin
      state_d        = COLLECT;
      count_d        = 3'd0;
      result_d       = '0;
      win_d          = 1'b0;
      rejected_d     = 1'b0;
      result_valid_d = 1'b0;
    end

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q        <= COLLECT;
      count_q        <= 3'd0;
      guess_q        <= '{default: '0};
      answer_q       <= '{default: '0};
      green_q        <= '0;
      consumed_q     <= '0;
      yellow_q       <= '0;
      idx_q          <= 3'd0;
      result_q       <= '0;
      win_q          <= 1'b0;
      busy_q         <= 1'b0;
      rejected_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      guess_q        <= guess_d;
      answer_q       <= answer_d;
      green_q        <= green_d;
      consumed_q     <= consumed_d;
      yellow_q       <= yellow_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      win_q          <= win_d;
      busy_q         <= busy_d;
      rejected_q     <= rejected_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign letter_count = count_q;
  assign busy         = busy_q;
  assign rejected     = rejected_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: directed words plus random guesses
// compared against a letter-counting Wordle model.
module tb_wordle_guess_scorer;

  logic        board_clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [24:0] answer = '0;
  logic [4:0]  letter_in = '0;
  logic        letter_push = 1'b0;
  logic        letter_pop = 1'b0;
  logic        submit = 1'b0;
  logic [2:0]  letter_count;
  logic        busy;
  logic        rejected;
  logic [9:0]  result;
  logic        result_valid;
  logic        win;

  int checks = 0;
  int errors = 0;

  wordle_guess_scorer dut (
    .board_clk    (board_clk),
    .reset        (reset),
    .clr          (clr),
    .answer       (answer),
    .letter_in    (letter_in),
    .letter_push  (letter_push),
    .letter_pop   (letter_pop),
    .submit       (submit),
    .letter_count (letter_count),
    .busy         (busy),
    .rejected     (rejected),
    .result       (result),
    .result_valid (result_valid),
    .win          (win)
  );

  always #5 board_clk = ~board_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [24:0] word(input string s);
    logic [24:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      w[i*5 +: 5] = 5'(s[i] - 8'd65);
    return w;
  endfunction

  // Standard Wordle scoring: greens first, then yellows drawn from a per-letter budget.
  function automatic logic [10:0] model_score(input logic [24:0] g, input logic [24:0] a);
    int         budget [32];
    bit         grn [5];
    logic [9:0] res;
    bit         all_green;
    for (int c = 0; c < 32; c++) budget[c] = 0;
    res = '0;
    all_green = 1'b1;
    for (int i = 0; i < 5; i++) begin
      grn[i] = (g[i*5 +: 5] == a[i*5 +: 5]);
      if (!grn[i]) begin
        budget[a[i*5 +: 5]]++;
        all_green = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (grn[i]) res[2*i +: 2] = 2'b10;
      else if (budget[g[i*5 +: 5]] > 0) begin
        res[2*i +: 2] = 2'b01;
        budget[g[i*5 +: 5]]--;
      end
    end
    return {all_green, res};
  endfunction

  task automatic drive(input bit p, input bit o, input bit s, input bit c, input logic [4:0] l);
    letter_push = p;
    letter_pop  = o;
    submit      = s;
    clr         = c;
    letter_in   = l;
    @(posedge board_clk);
    #1;
    letter_push = 1'b0;
    letter_pop  = 1'b0;
    submit      = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic run_guess(input logic [24:0] g, input logic [24:0] a,
                           output logic [9:0] res, output logic w, output int lat,
                           output logic [2:0] cnt_after, output logic busy_seen);
    answer = a;
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, g[i*5 +: 5]);
    drive(0, 0, 1, 0, 5'd0);
    busy_seen = busy;
    answer = 25'($urandom);
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(posedge board_clk);
      #1;
      lat++;
    end
    res = result;
    w = win;
    cnt_after = letter_count;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (letter_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", letter_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== 10'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 000", result); end
    checks++; if ({win, rejected, result_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {win, rejected, result_valid}); end
    @(negedge board_clk);
    reset = 1'b0;
    @(posedge board_clk);
    #1;
  endtask

  task automatic test_directed();
    logic [9:0] res; logic w; int lat; logic [2:0] cnt; logic bs;
    run_guess(word("CRANE"), word("CRANE"), res, w, lat, cnt, bs);
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL crane_latency: got %0d expected 7", lat); end
    checks++; if (res !== 10'h2AA) begin errors++; $display("[TB] FAIL crane_result: got %h expected 2aa", res); end
    checks++; if (w !== 1'b1) begin errors++; $display("[TB] FAIL crane_win: got %b expected 1", w); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("[TB] FAIL crane_count: got %0d expected 0", cnt); end
    checks++; if (bs !== 1'b1) begin errors++; $display("[TB] FAIL crane_busy: got %b expected 1", bs); end
    run_guess(word("BABES"), word("ABBEY"), res, w, lat, cnt, bs);
    checks++; if (res !== 10'h0A5) begin errors++; $display("[TB] FAIL babes_result: got %h expected 0a5", res); end
    checks++; if (w !== 1'b0) begin errors++; $display("[TB] FAIL babes_win: got %b expected 0", w); end
    run_guess(word("EERIE"), word("CRANE"), res, w, lat, cnt, bs);
    checks++; if (res !== 10'h210) begin errors++; $display("[TB] FAIL eerie_result: got %h expected 210", res); end
    checks++; if (w !== 1'b0) begin errors++; $display("[TB] FAIL eerie_win: got %b expected 0", w); end
  endtask

  task automatic test_random();
    logic [24:0] g, a; logic [10:0] exp; logic [9:0] res; logic w; int lat; logic [2:0] cnt; logic bs;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 5; i++) begin
        a[i*5 +: 5] = (n % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 25));
        g[i*5 +: 5] = (n % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 25));
      end
      if (n % 7 == 0) g = a;
      exp = model_score(g, a);
      run_guess(g, a, res, w, lat, cnt, bs);
      checks++; if (res !== exp[9:0]) begin errors++; $display("[TB] FAIL rand_result: guess %h answer %h got %h expected %h", g, a, res, exp[9:0]); end
      checks++; if (w !== exp[10]) begin errors++; $display("[TB] FAIL rand_win: got %b expected %b", w, exp[10]); end
      checks++; if (lat !== 7 || cnt !== 3'd0) begin errors++; $display("[TB] FAIL rand_timing: latency %0d count %0d expected 7 and 0", lat, cnt); end
    end
  endtask

  task automatic test_short_edit();
    int seen;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 5'($urandom_range(0, 25)));
    drive(0, 0, 1, 0, 5'd0);
    checks++; if (rejected !== 1'b1) begin errors++; $display("[TB] FAIL short_rejected: got %b expected 1", rejected); end
    checks++; if (letter_count !== 3'd3) begin errors++; $display("[TB] FAIL short_count: got %0d expected 3", letter_count); end
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge board_clk);
      #1;
      if (result_valid || busy) seen++;
      if (i == 0) begin
        checks++; if (rejected !== 1'b0) begin errors++; $display("[TB] FAIL short_pulse: got %b expected 0", rejected); end
      end
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL short_no_score: got %0d busy/valid cycles expected 0", seen); end
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 5'd0);
    checks++; if (letter_count !== 3'd0) begin errors++; $display("[TB] FAIL pop_floor: got %0d expected 0", letter_count); end
    drive(1, 0, 0, 0, 5'd27);
    checks++; if (letter_count !== 3'd0) begin errors++; $display("[TB] FAIL invalid_letter: got %0d expected 0", letter_count); end
  endtask

  task automatic test_limits();
    logic [24:0] g, a; logic [4:0] l; logic [10:0] exp; int lat, extra;
    g = '0;
    for (int i = 0; i < 6; i++) begin
      l = 5'($urandom_range(0, 25));
      if (i < 5) g[i*5 +: 5] = l;
      drive(1, 0, 0, 0, l);
    end
    checks++; if (letter_count !== 3'd5) begin errors++; $display("[TB] FAIL push_ceiling: got %0d expected 5", letter_count); end
    drive(1, 1, 0, 0, 5'd1);
    checks++; if (letter_count !== 3'd5) begin errors++; $display("[TB] FAIL push_pop_full: got %0d expected 5", letter_count); end
    drive(0, 1, 0, 0, 5'd0);
    drive(1, 1, 0, 0, 5'd2);
    checks++; if (letter_count !== 3'd4) begin errors++; $display("[TB] FAIL push_pop_mid: got %0d expected 4", letter_count); end
    l = 5'($urandom_range(0, 25));
    g[20 +: 5] = l;
    drive(1, 0, 0, 0, l);
    for (int i = 0; i < 5; i++) a[i*5 +: 5] = 5'($urandom_range(0, 25));
    a[0 +: 5] = g[20 +: 5];
    exp = model_score(g, a);
    answer = a;
    drive(0, 0, 1, 0, 5'd0);
    answer = ~a;
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 5'd3);
    checks++; if (letter_count !== 3'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_ignore: count %0d busy %b expected 5 and 1", letter_count, busy); end
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(posedge board_clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 4", lat); end
    checks++; if (result !== exp[9:0] || win !== exp[10]) begin errors++; $display("[TB] FAIL busy_result: got %h/%b expected %h/%b", result, win, exp[9:0], exp[10]); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge board_clk);
      #1;
      if (result_valid || busy || rejected) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL busy_submit_leak: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_abort_reset();
    logic [9:0] res; logic w; int lat, seen; logic [2:0] cnt; logic bs;
    run_guess(word("CRANE"), word("CRANE"), res, w, lat, cnt, bs);
    answer = word("SLATE");
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 5'(i));
    drive(0, 0, 1, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge board_clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || win !== 1'b0) begin errors++; $display("[TB] FAIL abort_reset_flags: busy %b win %b expected 0 0", busy, win); end
    checks++; if (result !== 10'h0 || letter_count !== 3'd0) begin errors++; $display("[TB] FAIL abort_reset_state: result %h count %0d expected 000 0", result, letter_count); end
    @(negedge board_clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge board_clk);
      #1;
      if (result_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_reset_leak: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_abort_clr();
    logic [9:0] res; logic w; int lat, seen; logic [2:0] cnt; logic bs;
    run_guess(word("CRANE"), word("CRANE"), res, w, lat, cnt, bs);
    answer = word("CRANE");
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 5'(i + 2));
    drive(0, 0, 1, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge board_clk);
      #1;
    end
    checks++; if (busy !== 1'b1 || result !== 10'h2AA) begin errors++; $display("[TB] FAIL clr_precondition: busy %b result %h expected 1 2aa", busy, result); end
    drive(0, 0, 0, 1, 5'd0);
    checks++; if (busy !== 1'b0 || win !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_flags: busy %b win %b valid %b expected 0 0 0", busy, win, result_valid); end
    checks++; if (result !== 10'h0 || letter_count !== 3'd0) begin errors++; $display("[TB] FAIL clr_state: result %h count %0d expected 000 0", result, letter_count); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge board_clk);
      #1;
      if (result_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL clr_leak: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_short_edit();
    test_limits();
    test_abort_reset();
    test_abort_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
